// File: rtl/conv_loop_sched.sv
// Three-level (row > col > ch) loop-nest scheduler emitting one index tuple per
// accepted valid/ready beat, with a one-cycle done pulse at layer completion.
module conv_loop_sched #(
  parameter int unsigned IDX_BITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [IDX_BITS-1:0] cfg_rows,
  input  logic [IDX_BITS-1:0] cfg_cols,
  input  logic [IDX_BITS-1:0] cfg_chs,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_BITS-1:0] row_idx,
  output logic [IDX_BITS-1:0] col_idx,
  output logic [IDX_BITS-1:0] ch_idx,
  output logic                ch_first,
  output logic                ch_last,
  output logic                tuple_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_BITS-1:0] ONE = IDX_BITS'(1);

  state_t              state, state_nxt;
  logic [IDX_BITS-1:0] rows_q, cols_q, chs_q;
  logic                beat, launch, any_zero;
  logic                row_wrap, col_wrap, ch_wrap;
  logic                row_last, col_last;

  // Wrap uses >= so an index can never run past bound-1; flags use exact match.
  always_comb begin
    beat     = (state == RUN) && out_ready;
    launch   = (state == IDLE) && start && !abort;
    any_zero = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_chs == '0);
    row_wrap = row_idx >= (rows_q - ONE);
    col_wrap = col_idx >= (cols_q - ONE);
    ch_wrap  = ch_idx  >= (chs_q  - ONE);
    row_last = row_idx == (rows_q - ONE);
    col_last = col_idx == (cols_q - ONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = any_zero ? DONE : RUN;
      RUN: begin
        if (abort)                   state_nxt = IDLE;
        else if (beat && tuple_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state == RUN);
    busy       = (state != IDLE);
    done       = (state == DONE) && !abort;
    ch_first   = (ch_idx == '0);
    ch_last    = (ch_idx == (chs_q - ONE));
    tuple_last = row_last && col_last && ch_last;
  end

  // The final beat wraps every level at once, so indices land on 0 naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q  <= '0;
      cols_q  <= '0;
      chs_q   <= '0;
      row_idx <= '0;
      col_idx <= '0;
      ch_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            rows_q  <= cfg_rows;
            cols_q  <= cfg_cols;
            chs_q   <= cfg_chs;
            row_idx <= '0;
            col_idx <= '0;
            ch_idx  <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            row_idx <= '0;
            col_idx <= '0;
            ch_idx  <= '0;
          end else if (beat) begin
            if (ch_wrap) begin
              ch_idx <= '0;
              if (col_wrap) begin
                col_idx <= '0;
                row_idx <= row_wrap ? '0 : row_idx + ONE;
              end else begin
                col_idx <= col_idx + ONE;
              end
            end else begin
              ch_idx <= ch_idx + ONE;
            end
          end
        end
        default: begin
          row_idx <= '0;
          col_idx <= '0;
          ch_idx  <= '0;
        end
      endcase
    end
  end

endmodule
